// File: rtl/local_ni.sv
// local_ni: network interface on a router LOCAL port; single-flit TX packetizer and RX sink.
// Optional statistics counters are built when NI_STAT_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module local_ni #(
    parameter logic [2:0] NODE_ADDRESS = 3'b0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [2:0]             tx_dst,
    input  logic [`DATA_WIDTH-7:0] tx_payload,
    output logic [`DATA_WIDTH-1:0] NI_DATA_OUT,
    output logic                   NI_DATA_VALID_OUT,
    input  logic                   NI_FULL_IN,
    input  logic [`DATA_WIDTH-1:0] NI_DATA_IN,
    input  logic                   NI_DATA_VALID_IN,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [2:0]             rx_src,
    output logic [`DATA_WIDTH-7:0] rx_payload,
    input  logic                   stat_clr,
    output logic                   rx_overflow,
    output logic                   misroute,
    output logic [15:0]            tx_cnt,
    output logic [15:0]            rx_cnt,
    output logic [15:0]            drop_cnt
);
    localparam int DW  = `DATA_WIDTH;
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    logic [DW-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]  tx_wp, tx_rp;
    logic          tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty          = tx_wp == tx_rp;
    assign tx_full           = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
    assign NI_DATA_VALID_OUT = !tx_empty && !NI_FULL_IN;
    assign tx_pop            = NI_DATA_VALID_OUT;
    assign tx_ready          = !tx_full || tx_pop;
    assign tx_push           = tx_valid && tx_ready;
    assign NI_DATA_OUT       = tx_mem[tx_rp[TAW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[TAW-1:0]] <= {tx_payload, NODE_ADDRESS, tx_dst};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    // RX entries drop the dst field: it is only needed for the misroute check on arrival.
    logic [DW-4:0] rx_mem [RX_DEPTH];
    logic [DW-4:0] rx_head;
    logic [RAW:0]  rx_wp, rx_rp;
    logic          rx_empty, rx_full, rx_push, rx_pop, rx_drop;

    assign rx_empty   = rx_wp == rx_rp;
    assign rx_full    = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
    assign rx_valid   = !rx_empty;
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_push    = NI_DATA_VALID_IN && (!rx_full || rx_pop);
    assign rx_drop    = NI_DATA_VALID_IN && !rx_push;
    assign rx_head    = rx_mem[rx_rp[RAW-1:0]];
    assign rx_src     = rx_head[2:0];
    assign rx_payload = rx_head[DW-4:3];

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wp[RAW-1:0]] <= NI_DATA_IN[DW-1:3];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // A set event in the same cycle as stat_clr wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_overflow <= 1'b0;
            misroute    <= 1'b0;
        end else begin
            rx_overflow <= rx_drop || (rx_overflow && !stat_clr);
            misroute    <= (rx_push && NI_DATA_IN[2:0] != NODE_ADDRESS) || (misroute && !stat_clr);
        end
    end

`ifdef NI_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            tx_cnt   <= tx_pop  ? (stat_clr ? 16'd1 : (&tx_cnt ? tx_cnt : tx_cnt + 16'd1))
                                : (stat_clr ? 16'd0 : tx_cnt);
            rx_cnt   <= rx_push ? (stat_clr ? 16'd1 : (&rx_cnt ? rx_cnt : rx_cnt + 16'd1))
                                : (stat_clr ? 16'd0 : rx_cnt);
            drop_cnt <= rx_drop ? (stat_clr ? 16'd1 : (&drop_cnt ? drop_cnt : drop_cnt + 16'd1))
                                : (stat_clr ? 16'd0 : drop_cnt);
        end
    end
`else
    assign tx_cnt   = '0;
    assign rx_cnt   = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_local_ni.sv
// tb_local_ni: directed scoreboard bench for local_ni with NODE_ADDRESS=3.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_local_ni;
    localparam int DW = `DATA_WIDTH;
    localparam logic [2:0] NODE = 3'd3;

    logic          clk = 0;
    logic          rst_n, tx_valid, tx_ready, NI_DATA_VALID_OUT, NI_FULL_IN;
    logic [2:0]    tx_dst, rx_src;
    logic [DW-7:0] tx_payload, rx_payload;
    logic [DW-1:0] NI_DATA_OUT, NI_DATA_IN;
    logic          NI_DATA_VALID_IN, rx_valid, rx_ready, stat_clr, rx_overflow, misroute;
    logic [15:0]   tx_cnt, rx_cnt, drop_cnt;

    local_ni #(.NODE_ADDRESS(NODE), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst),
        .tx_payload(tx_payload), .NI_DATA_OUT(NI_DATA_OUT), .NI_DATA_VALID_OUT(NI_DATA_VALID_OUT),
        .NI_FULL_IN(NI_FULL_IN), .NI_DATA_IN(NI_DATA_IN), .NI_DATA_VALID_IN(NI_DATA_VALID_IN),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_payload(rx_payload),
        .stat_clr(stat_clr), .rx_overflow(rx_overflow), .misroute(misroute),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int exp_tx = 0, exp_rx = 0, exp_drop = 0;
    logic [DW-1:0] tx_q [$];
    logic [DW-4:0] rx_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cexp(input int v);
`ifdef NI_STAT_EN
        return 16'(v);
`else
        return (v == v) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: flits leaving the DUT are compared against the queued expectations.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && NI_DATA_VALID_OUT === 1'b1) begin
            if (tx_q.size() == 0) chk("tx_unexpected", 64'(NI_DATA_OUT), 64'hDEAD);
            else chk("tx_flit", 64'(NI_DATA_OUT), 64'(tx_q.pop_front()));
            exp_tx++;
        end
        if (rst_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (rx_q.size() == 0) chk("rx_unexpected", 64'({rx_payload, rx_src}), 64'hDEAD);
            else chk("rx_flit", 64'({rx_payload, rx_src}), 64'(rx_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-7:0] pl;
        rst_n = 0; tx_valid = 0; tx_dst = 0; tx_payload = 0; NI_FULL_IN = 0;
        NI_DATA_IN = 0; NI_DATA_VALID_IN = 0; rx_ready = 0; stat_clr = 0;
        tick(); tick();
        rst_n = 1;
        #1;
        chk("rst_tx_ready", 64'(tx_ready), 1);
        chk("rst_valid_out", 64'(NI_DATA_VALID_OUT), 0);
        chk("rst_rx_valid", 64'(rx_valid), 0);
        chk("rst_overflow", 64'(rx_overflow), 0);
        chk("rst_misroute", 64'(misroute), 0);
        chk("rst_cnts", 64'({tx_cnt, rx_cnt, drop_cnt}), 0);

        // single flit, one-cycle latency
        tx_valid = 1; tx_dst = 3'd5; tx_payload = (DW-6)'(8'h2A);
        tx_q.push_back({tx_payload, NODE, 3'd5});
        tick();
        tx_valid = 0;
        #1;
        chk("single_valid", 64'(NI_DATA_VALID_OUT), 1);
        chk("single_flit", 64'(NI_DATA_OUT), 64'({(DW-6)'(8'h2A), 3'd3, 3'd5}));
        tick();
        chk("single_tx_cnt", 64'(tx_cnt), 64'(cexp(exp_tx)));

        // fill TX while the router is full
        NI_FULL_IN = 1;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1; tx_dst = 3'(i + 1); tx_payload = (DW-6)'($urandom);
            tx_q.push_back({tx_payload, NODE, tx_dst});
            tick();
        end
        tx_valid = 0;
        #1;
        chk("full_tx_ready", 64'(tx_ready), 0);
        chk("full_valid_out", 64'(NI_DATA_VALID_OUT), 0);
        tick();
        // push and pop together while full
        NI_FULL_IN = 0; tx_valid = 1; tx_dst = NODE; tx_payload = (DW-6)'($urandom);
        tx_q.push_back({tx_payload, NODE, NODE});
        #1;
        chk("overlap_ready", 64'(tx_ready), 1);
        chk("overlap_valid", 64'(NI_DATA_VALID_OUT), 1);
        tick();
        tx_valid = 0; NI_FULL_IN = 1;
        #1;
        chk("overlap_still_full", 64'(tx_ready), 0);
        tick();
        NI_FULL_IN = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 64'(NI_DATA_VALID_OUT), 1);
            tick();
        end
        #1;
        chk("drain_done_valid", 64'(NI_DATA_VALID_OUT), 0);
        chk("drain_done_ready", 64'(tx_ready), 1);
        chk("drain_tx_q", 64'(tx_q.size()), 0);
        chk("drain_tx_cnt", 64'(tx_cnt), 64'(cexp(exp_tx)));

        // RX overflow with core stalled
        rx_ready = 0;
        for (int i = 0; i < 5; i++) begin
            pl = (DW-6)'($urandom);
            NI_DATA_VALID_IN = 1; NI_DATA_IN = {pl, 3'(i), NODE};
            if (i < 4) begin rx_q.push_back({pl, 3'(i)}); exp_rx++; end
            else exp_drop++;
            tick();
        end
        NI_DATA_VALID_IN = 0;
        #1;
        chk("ovf_flag", 64'(rx_overflow), 1);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'(cexp(exp_drop)));
        chk("ovf_rx_cnt", 64'(rx_cnt), 64'(cexp(exp_rx)));
        chk("ovf_rx_valid", 64'(rx_valid), 1);
        chk("ovf_head_src", 64'(rx_src), 0);
        chk("ovf_misroute", 64'(misroute), 0);
        rx_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("rx_drained", 64'(rx_valid), 0);
        chk("rx_q_empty", 64'(rx_q.size()), 0);

        // misrouted flit still delivered
        pl = (DW-6)'($urandom);
        NI_DATA_VALID_IN = 1; NI_DATA_IN = {pl, 3'd1, 3'd6};
        rx_q.push_back({pl, 3'd1}); exp_rx++;
        tick();
        NI_DATA_VALID_IN = 0;
        #1;
        chk("misroute_set", 64'(misroute), 1);
        chk("misroute_rx_valid", 64'(rx_valid), 1);
        tick();
        stat_clr = 1;
        tick();
        stat_clr = 0; exp_tx = 0; exp_rx = 0; exp_drop = 0;
        #1;
        chk("clr_misroute", 64'(misroute), 0);
        chk("clr_overflow", 64'(rx_overflow), 0);
        chk("clr_cnts", 64'({tx_cnt, rx_cnt, drop_cnt}), 0);
        chk("clr_rx_q", 64'(rx_q.size()), 0);

        // set wins over a coincident clear
        pl = (DW-6)'($urandom);
        stat_clr = 1; NI_DATA_VALID_IN = 1; NI_DATA_IN = {pl, 3'd2, 3'd7};
        rx_q.push_back({pl, 3'd2}); exp_rx++;
        tick();
        stat_clr = 0; NI_DATA_VALID_IN = 0;
        #1;
        chk("setwin_misroute", 64'(misroute), 1);
        chk("setwin_rx_cnt", 64'(rx_cnt), 64'(cexp(exp_rx)));
        tick();

        // reset with flits queued on both sides
        rx_ready = 0; NI_FULL_IN = 1;
        for (int i = 0; i < 2; i++) begin
            tx_valid = 1; tx_dst = 3'd1; tx_payload = (DW-6)'($urandom);
            NI_DATA_VALID_IN = 1; NI_DATA_IN = {(DW-6)'($urandom), 3'd4, NODE};
            tick();
        end
        tx_valid = 0; NI_DATA_VALID_IN = 0; rst_n = 0;
        tick();
        rst_n = 1; NI_FULL_IN = 0; exp_tx = 0; exp_rx = 0; exp_drop = 0;
        #1;
        chk("midrst_valid_out", 64'(NI_DATA_VALID_OUT), 0);
        chk("midrst_rx_valid", 64'(rx_valid), 0);
        chk("midrst_tx_ready", 64'(tx_ready), 1);
        chk("midrst_misroute", 64'(misroute), 0);
        chk("midrst_cnts", 64'({tx_cnt, rx_cnt, drop_cnt}), 0);
        rx_ready = 1;
        tick(); tick();
        chk("end_tx_q", 64'(tx_q.size()), 0);
        chk("end_rx_q", 64'(rx_q.size()), 0);
        chk("end_rx_valid", 64'(rx_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
